// File: rtl/codes_pkg.sv
// Shared ALU definitions: operation codes and the default datapath width.
// The MUL code always exists. It is only executed as a multiply when the
// ALU_MUL_EN macro is defined.
package codes_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    // Operation codes from the ALU control decoder.
    // Any code not listed here executes as ADD.
    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluSlt  = 4'd4,
        AluSltu = 4'd5,
        AluMul  = 4'd6
    } alu_control;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier. It takes XLEN cycles per product.
// 'start' loads the operands and clears the iteration counter.
// 'done' is high during the last iteration.
// 'product' carries the running sum including the current iteration,
// so during 'done' it already holds the final low XLEN bits.
module alu_mul_seq
    import codes_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int unsigned CntW = (XLEN > 1) ? $clog2(XLEN) : 1;

    logic [CntW-1:0] cnt;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;

    // Partial sum for this iteration, and detection of the final iteration.
    always_comb begin
        product = acc + (mplier[0] ? mcand : '0);
        done    = busy && (cnt == CntW'(XLEN - 1));
    end

    // Operand shift registers, accumulator and iteration counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage with a valid/ready handshake on input and output.
// Single-cycle ops register their result on the accept edge.
// Defining ALU_MUL_EN adds a sequential multiplier, and MUL then stays
// BUSY for XLEN cycles. Without the macro, MUL executes as ADD.
module alu_exec
    import codes_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  alu_control      control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state;
    logic            accept;
    logic            start_mul;
    logic [XLEN-1:0] alu_res;

    // A held result may be replaced in the same cycle it is consumed.
    always_comb begin
        in_ready = (state == StIdle) || ((state == StDone) && out_ready);
        accept   = in_valid && in_ready;
    end

    // Single-cycle datapath. Unlisted codes fall through to ADD.
    always_comb begin
        alu_res = op_a + op_b;
        case (control)
            AluSub:  alu_res = op_a - op_b;
            AluAnd:  alu_res = op_a & op_b;
            AluOr:   alu_res = op_a | op_b;
            AluSlt:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            AluSltu: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default: alu_res = op_a + op_b;
        endcase
    end

`ifdef ALU_MUL_EN
    logic            mul_busy;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    assign start_mul = accept && (control == AluMul);

    alu_mul_seq #(
        .XLEN (XLEN)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_mul),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign start_mul = 1'b0;
`endif

    // Control FSM. result, zero and out_valid are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (accept) begin
                        if (start_mul) begin
                            state     <= StBusy;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= StDone;
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                        end
                    end else if ((state == StDone) && out_ready) begin
                        state     <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                StBusy: begin
`ifdef ALU_MUL_EN
                    if (mul_busy && mul_done) begin
                        state     <= StDone;
                        out_valid <= 1'b1;
                        result    <= mul_product;
                        zero      <= (mul_product == '0);
                    end
`else
                    state <= StIdle;
`endif
                end
                default: begin
                    state     <= StIdle;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec. It holds a transaction-level model
// (pending latency plus expected result) that is checked every cycle,
// together with directed vectors that have literal expectations.
// Build with ALU_MUL_EN to exercise the multiplier path.
module tb_alu_exec;
    import codes_pkg::*;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    alu_control      control = AluAdd;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            zero;

    int checks = 0;
    int errors = 0;
    bit run_chk = 1'b0;

`ifdef ALU_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    alu_exec #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .control   (control),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Golden operation semantics, written as plain arithmetic.
    function automatic logic [XLEN-1:0] golden(input alu_control c, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        case (c)
            AluSub:  return a - b;
            AluAnd:  return a & b;
            AluOr:   return a | b;
            AluSlt:  return ($signed(a) < $signed(b)) ? 1 : 0;
            AluSltu: return (a < b) ? 1 : 0;
            AluMul: begin
                if (MulEn) begin
                    p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
                    return p[XLEN-1:0];
                end
                return a + b;
            end
            default: return a + b;
        endcase
    endfunction

    // Model state: a held result, or cycles left until a pending one appears.
    bit              m_valid = 1'b0;
    int              m_wait = 0;
    logic [XLEN-1:0] m_res = '0;
    logic [XLEN-1:0] m_pend = '0;

    always @(posedge clk) begin
        bit m_acc;
        m_acc = in_valid && (m_wait == 0) && (!m_valid || out_ready);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_wait  = 0;
            m_res   = '0;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_res   = m_pend;
            end
        end else if (m_acc) begin
            if (MulEn && control == AluMul) begin
                m_valid = 1'b0;
                m_wait  = XLEN;
                m_pend  = golden(control, op_a, op_b);
            end else begin
                m_valid = 1'b1;
                m_res   = golden(control, op_a, op_b);
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (run_chk) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            chk("in_ready", {31'b0, in_ready},
                {31'b0, (m_wait == 0) && (!m_valid || out_ready)});
            if (m_valid) begin
                chk("result", result, m_res);
                chk("zero", {31'b0, zero}, {31'b0, (m_res == '0)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one edge, then drop it and scramble the operands.
    task automatic issue(input alu_control c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        control  = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        control  = AluSub;
    endtask

    initial begin
        int n;
        // Reset
        rst_n = 1'b0;
        tick();
        run_chk = 1'b1;
        tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Single-cycle ops, back to back
        out_ready = 1'b1;
        issue(AluAdd, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add_res", result, 32'h8000_0000);
        chk("add_zero", {31'b0, zero}, 32'd0);
        issue(AluSub, 32'd5, 32'd5);
        chk("sub_res", result, 32'd0);
        chk("sub_zero", {31'b0, zero}, 32'd1);
        issue(AluSlt, 32'hFFFF_FFFF, 32'd1);
        chk("slt_res", result, 32'd1);
        issue(AluSltu, 32'hFFFF_FFFF, 32'd1);
        chk("sltu_res", result, 32'd0);
        issue(alu_control'(4'hF), 32'd1, 32'd2);
        chk("unlisted_res", result, 32'd3);
        tick();
        chk("idle_out_valid", {31'b0, out_valid}, 32'd0);

        // AND held under backpressure while an OR waits
        out_ready = 1'b0;
        issue(AluAnd, 32'hF0F0_00FF, 32'hFF00_0F0F);
        control  = AluOr;
        op_a     = 32'h1200_0034;
        op_b     = 32'h0056_7800;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("stall_res", result, 32'hF000_000F);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("or_valid", {31'b0, out_valid}, 32'd1);
        chk("or_res", result, 32'h1256_7834);
        tick();

        // MUL
        issue(AluMul, 32'h1234_5678, 32'h0000_0010);
        if (MulEn) begin
            n = 0;
            while (!out_valid && n < 40) begin
                chk("mul_in_ready", {31'b0, in_ready}, 32'd0);
                tick();
                n++;
            end
            chk("mul_latency", n, 32'd32);
            chk("mul_res", result, 32'h2345_6780);
        end else begin
            chk("mul_as_add_valid", {31'b0, out_valid}, 32'd1);
            chk("mul_as_add_res", result, 32'h1234_5688);
        end
        tick();

        // Reset in the middle of a multiply
        issue(AluMul, 32'h0000_0003, 32'h0000_0007);
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_res", result, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (40) tick();
        chk("mid_rst_no_pulse", {31'b0, out_valid}, 32'd0);
        issue(AluAdd, 32'd2, 32'd3);
        chk("post_rst_add", result, 32'd5);

        // Random traffic, checked by the model every cycle
        for (int i = 0; i < 300; i++) begin
            n = $urandom_range(0, 7);
            control   = (n == 7) ? alu_control'(4'hF) : alu_control'(n[3:0]);
            op_a      = ($urandom_range(0, 3) == 0) ? 32'd9 : $urandom;
            op_b      = ($urandom_range(0, 3) == 0) ? 32'd9 : $urandom;
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
